// File: rtl/seq_mult_pkg.sv
// Shared definitions for seq_mult: FSM state encoding and default operand width.
package seq_mult_pkg;

  localparam int unsigned SEQ_MULT_DEFAULT_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// seq_mult: radix-2 sequential shift-add multiplier, one multiplier bit per cycle.
// Configuration macro: SEQ_MULT_SIGNED_EN (defined: sgn selects two's complement
// operands; undefined: sgn is ignored and every operation is unsigned).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair offered        in_ready   block can accept operands
//   a, b       multiplicand / multiplier   sgn        signed operands when 1
//   out_valid  product valid               out_ready  consumer accepts product
//   product    2W-bit result, held until the next result is written
//   busy       operation in progress or result pending
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned W = SEQ_MULT_DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    mag_a_c;
  logic [W-1:0]    mag_b_c;
  logic [PW-1:0]   addend_c;
  logic [PW-1:0]   sum_c;
  logic [PW-1:0]   result_c;
  logic            last_c;

`ifdef SEQ_MULT_SIGNED_EN
  logic            neg;
  logic            neg_c;

  // Magnitudes of signed operands; -2^(W-1) maps to 2^(W-1), which fits unsigned W bits.
  always_comb begin
    neg_c    = sgn & (a[W-1] ^ b[W-1]);
    mag_a_c  = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    mag_b_c  = (sgn && b[W-1]) ? (~b + W'(1)) : b;
    result_c = neg ? (~sum_c + PW'(1)) : sum_c;
  end
`else
  logic            unused_sgn;

  assign unused_sgn = sgn;

  always_comb begin
    mag_a_c  = a;
    mag_b_c  = b;
    result_c = sum_c;
  end
`endif

  // One shift-add step; the final step's sum is the magnitude of the product.
  always_comb begin
    addend_c = mplier[0] ? mcand : '0;
    sum_c    = acc + addend_c;
    last_c   = (cnt == CW'(W - 1));
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_c)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // State register and registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

  // Datapath: capture in IDLE, iterate in RUN, product written only on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= PW'(mag_a_c);
            mplier <= mag_b_c;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= neg_c;
`endif
          end
        end
        RUN: begin
          acc    <= sum_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_c) product <= result_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter W, default 12, operand width; legal range 2..32.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  multiplicand.
REQ-007 SHALL have port b  input  W  multiplier.
REQ-008 SHALL have port sgn  input  1  1 = treat a, b as two's complement; 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  product valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts product.
REQ-011 SHALL have port product  output  2W  result.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 at an edge SHALL capture a, b, sgn, clear accumulator and counter, and go to RUN.
REQ-015 RUN: radix-2 shift-add, one multiplier bit per cycle, LSB first; exactly W cycles, then DONE.
REQ-016 Latency: accept at edge T SHALL give out_valid=1 and final product after edge T+W.
REQ-017 DONE: out_valid=1, product held stable; out_ready=1 at an edge SHALL go to IDLE and clear out_valid.
REQ-018 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, with operands not captured.
REQ-019 out_ready while out_valid=0 SHALL be ignored.
REQ-020 Minimum spacing between accepts SHALL be W+2 cycles; no overlapped operations.
REQ-021 Unsigned: product = a*b exact in 2W bits.
REQ-022 Signed: magnitudes multiplied, result negated in two's complement when sign(a) xor sign(b); -2^(W-1) operands handled exactly, so (-2^(W-1))^2 = 2^(2W-2).
REQ-023 Iteration counter SHALL be clog2(W+1) bits wide and SHALL NOT wrap before W iterations for any legal W, including powers of two.
REQ-024 product SHALL hold the last result through IDLE until the next result is written at DONE entry.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE and set in_ready=1, out_valid=0, busy=0, product=0, and clear the accumulator and counter.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no partial result visible; the first operation after reset SHALL be correct.

Configuration
REQ-027 Macro SEQ_MULT_SIGNED_EN defined: sgn honoured per REQ-022.
REQ-028 Macro SEQ_MULT_SIGNED_EN undefined: port sgn still present but ignored; all operations unsigned; no sign/negate logic synthesised.

Structure
REQ-029 Package seq_mult_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default width constant.
REQ-030 No sub-module; FSM and datapath SHALL be in seq_mult.

Verification
REQ-031 W=12, sgn=0, a=0xFFF, b=0xFFF -> product=0xFFE001, out_valid exactly 12 cycles after accept.
REQ-032 W=12, a=0xFFF, b=0x003, sgn=1 -> 0xFFFFFD with SEQ_MULT_SIGNED_EN; 0x002FFD without.
REQ-033 W=12, sgn=1, a=b=0x800 (macro on) -> 0x400000; a=0x800, b=0x001 -> 0xFFF800.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while driving new in_valid -> product stable, in_ready=0, new operands not taken; after out_ready, next accept yields its own correct result.
REQ-035 rst_n=0 on the 5th RUN cycle -> next edge: IDLE, out_valid=0, product=0; following 7*9 -> 63.
REQ-036 Randomised 1000 operand pairs, W=8 and W=16, both sgn values -> matches reference model; W=16 latency 16 cycles.
